// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the unified instruction/data memory port.
package riscv_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        I_WAIT,
        D_WAIT,
        I_RESP,
        D_RESP
    } arb_state_t;

    typedef enum logic {
        GNT_I,
        GNT_D
    } grant_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts wait cycles of an outstanding memory access and flags when the limit is reached.
module mem_wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wait_cnt <= '0;
        end else if (inc) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign expired_c = (wait_cnt == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data accesses onto one single-port memory and drives pipeline stalls.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_f,
    output logic              stall_m,
    output logic              timeout_err
);

    arb_state_t        state, state_d;
    grant_t            last_grant, last_grant_d;
    logic              mem_req_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d, if_rdata_d, dm_rdata_d;
    logic              timeout_err_d, kill_pend, kill_pend_d;
    logic              want_i, kill_now, grant, timer_inc, expired_c;

    mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (grant),
        .inc       (timer_inc),
        .expired_c (expired_c)
    );

    assign want_i = if_req & ~if_kill;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d       = state;
        last_grant_d  = last_grant;
        mem_req_d     = mem_req;
        mem_we_d      = mem_we;
        mem_addr_d    = mem_addr;
        mem_wdata_d   = mem_wdata;
        if_rdata_d    = if_rdata;
        dm_rdata_d    = dm_rdata;
        timeout_err_d = timeout_err;
        kill_pend_d   = kill_pend;
        kill_now      = kill_pend | if_kill;
        grant         = 1'b0;
        timer_inc     = 1'b0;

        case (state)
            IDLE: begin
                // On conflict the side that did not win last time gets the port
                if (dm_req && (!want_i || last_grant == GNT_I)) begin
                    state_d      = D_WAIT;
                    grant        = 1'b1;
                    last_grant_d = GNT_D;
                    mem_req_d    = 1'b1;
                    mem_we_d     = dm_we;
                    mem_addr_d   = dm_addr;
                    mem_wdata_d  = dm_wdata;
                end else if (want_i) begin
                    state_d      = I_WAIT;
                    grant        = 1'b1;
                    last_grant_d = GNT_I;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = if_addr;
                end
            end
            I_WAIT: begin
                kill_pend_d = kill_now;
                if (mem_ack || expired_c) begin
                    if_rdata_d    = mem_ack ? mem_rdata : DATA_W'(NOP_INSTR);
                    timeout_err_d = timeout_err | ~mem_ack;
                    mem_req_d     = 1'b0;
                    kill_pend_d   = 1'b0;
                    state_d       = kill_now ? IDLE : I_RESP;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            D_WAIT: begin
                if (mem_ack || expired_c) begin
                    // Stores leave the load data register untouched
                    if (!mem_we) dm_rdata_d = mem_ack ? mem_rdata : '0;
                    timeout_err_d = timeout_err | ~mem_ack;
                    mem_req_d     = 1'b0;
                    mem_we_d      = 1'b0;
                    state_d       = D_RESP;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            I_RESP:  state_d = IDLE;
            D_RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant  <= GNT_I;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            if_rdata    <= '0;
            dm_rdata    <= '0;
            timeout_err <= 1'b0;
            kill_pend   <= 1'b0;
        end else begin
            last_grant  <= last_grant_d;
            mem_req     <= mem_req_d;
            mem_we      <= mem_we_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            if_rdata    <= if_rdata_d;
            dm_rdata    <= dm_rdata_d;
            timeout_err <= timeout_err_d;
            kill_pend   <= kill_pend_d;
        end
    end

    // Completion pulses are state decodes so a late if_kill can still squash the fetch
    assign if_valid = (state == I_RESP) & ~if_kill;
    assign dm_valid = (state == D_RESP);
    assign stall_m  = dm_req & ~dm_valid;
    assign stall_f  = (if_req & ~if_valid & ~if_kill) | stall_m;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed checks of the fetch/data memory port arbiter: vector table plus corner sequences.
module tb_mem_port_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam int   NV = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_kill, dm_req, dm_we, mem_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_valid, dm_valid, mem_req, mem_we, stall_f, stall_m, timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        rst, if_req;
        logic [31:0] if_addr;
        logic        if_kill, dm_req, dm_we;
        logic [31:0] dm_addr, dm_wdata;
        logic        mem_ack;
        logic [31:0] mem_rdata;
        logic        x_mem_req, x_mem_we;
        logic [31:0] x_mem_addr, x_mem_wdata;
        logic        x_if_valid;
        logic [31:0] x_if_rdata;
        logic        x_dm_valid;
        logic [31:0] x_dm_rdata;
        logic        x_stall_f, x_stall_m;
    } vec_t;

    vec_t vecs [NV];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_kill     (if_kill),
        .if_rdata    (if_rdata),
        .if_valid    (if_valid),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_rdata    (dm_rdata),
        .dm_valid    (dm_valid),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .stall_f     (stall_f),
        .stall_m     (stall_m),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        //             rst if_req if_addr     kill dm_req we  dm_addr      dm_wdata     ack mem_rdata     | mreq mwe maddr        mwdata       ifv if_rdata      dmv dm_rdata      sf sm
        vecs[0]  = '{L, H, 32'h0000_0100, L, L, L, 32'h0,        32'h0,        L, 32'h0,         L, L, 32'h0,        32'h0,        L, 32'h0,         L, 32'h0,         H, L};
        vecs[1]  = '{L, H, 32'h0000_0100, L, L, L, 32'h0,        32'h0,        H, 32'h0050_0093, H, L, 32'h0000_0100, 32'h0,       L, 32'h0,         L, 32'h0,         H, L};
        vecs[2]  = '{L, H, 32'h0000_0100, L, L, L, 32'h0,        32'h0,        L, 32'h0,         L, L, 32'h0000_0100, 32'h0,       H, 32'h0050_0093, L, 32'h0,         L, L};
        vecs[3]  = '{L, L, 32'h0,         L, L, L, 32'h0,        32'h0,        L, 32'h0,         L, L, 32'h0000_0100, 32'h0,       L, 32'h0050_0093, L, 32'h0,         L, L};
        vecs[4]  = '{L, L, 32'h0,         L, H, L, 32'h0000_0080, 32'h0,       L, 32'h0,         L, L, 32'h0000_0100, 32'h0,       L, 32'h0050_0093, L, 32'h0,         H, H};
        vecs[5]  = '{L, L, 32'h0,         L, H, L, 32'h0000_0080, 32'h0,       H, 32'hCAFE_F00D, H, L, 32'h0000_0080, 32'h0,       L, 32'h0050_0093, L, 32'h0,         H, H};
        vecs[6]  = '{L, L, 32'h0,         L, H, L, 32'h0000_0080, 32'h0,       L, 32'h0,         L, L, 32'h0000_0080, 32'h0,       L, 32'h0050_0093, H, 32'hCAFE_F00D, L, L};
        vecs[7]  = '{L, L, 32'h0,         L, L, L, 32'h0,        32'h0,        L, 32'h0,         L, L, 32'h0000_0080, 32'h0,       L, 32'h0050_0093, L, 32'hCAFE_F00D, L, L};
        vecs[8]  = '{L, L, 32'h0,         L, H, H, 32'h0000_0040, 32'hDEAD_BEEF, L, 32'h0,       L, L, 32'h0000_0080, 32'h0,       L, 32'h0050_0093, L, 32'hCAFE_F00D, H, H};
        vecs[9]  = '{L, L, 32'h0,         L, H, H, 32'h0000_0040, 32'hDEAD_BEEF, L, 32'h0,       H, H, 32'h0000_0040, 32'hDEAD_BEEF, L, 32'h0050_0093, L, 32'hCAFE_F00D, H, H};
        vecs[10] = '{L, L, 32'h0,         L, H, H, 32'h0000_0040, 32'hDEAD_BEEF, L, 32'h0,       H, H, 32'h0000_0040, 32'hDEAD_BEEF, L, 32'h0050_0093, L, 32'hCAFE_F00D, H, H};
        vecs[11] = '{L, L, 32'h0,         L, H, H, 32'h0000_0040, 32'hDEAD_BEEF, L, 32'h0,       H, H, 32'h0000_0040, 32'hDEAD_BEEF, L, 32'h0050_0093, L, 32'hCAFE_F00D, H, H};
        vecs[12] = '{L, L, 32'h0,         L, H, H, 32'h0000_0040, 32'hDEAD_BEEF, H, 32'h1234_5678, H, H, 32'h0000_0040, 32'hDEAD_BEEF, L, 32'h0050_0093, L, 32'hCAFE_F00D, H, H};
        vecs[13] = '{L, L, 32'h0,         L, H, H, 32'h0000_0040, 32'hDEAD_BEEF, L, 32'h0,       L, L, 32'h0000_0040, 32'hDEAD_BEEF, L, 32'h0050_0093, H, 32'hCAFE_F00D, L, L};
        vecs[14] = '{L, L, 32'h0,         L, L, L, 32'h0,        32'h0,        H, 32'hFFFF_FFFF, L, L, 32'h0000_0040, 32'hDEAD_BEEF, L, 32'h0050_0093, L, 32'hCAFE_F00D, L, L};
        vecs[15] = '{L, L, 32'h0,         L, L, L, 32'h0,        32'h0,        L, 32'h0,         L, L, 32'h0000_0040, 32'hDEAD_BEEF, L, 32'h0050_0093, L, 32'hCAFE_F00D, L, L};

        // Reset state
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        smp();
        chk("rst_mem_req", 32'(mem_req), 32'(L));
        chk("rst_mem_we", 32'(mem_we), 32'(L));
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'(L));
        chk("rst_dm_valid", 32'(dm_valid), 32'(L));
        chk("rst_timeout_err", 32'(timeout_err), 32'(L));
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);

        // Vector table: zero-wait fetch, zero-wait load, store with 3 wait states, ack in IDLE
        for (int i = 0; i < NV; i++) begin
            cyc();
            rst = vecs[i].rst; if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
            if_kill = vecs[i].if_kill; dm_req = vecs[i].dm_req; dm_we = vecs[i].dm_we;
            dm_addr = vecs[i].dm_addr; dm_wdata = vecs[i].dm_wdata;
            mem_ack = vecs[i].mem_ack; mem_rdata = vecs[i].mem_rdata;
            smp();
            chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(vecs[i].x_mem_req));
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].x_mem_we));
            chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].x_mem_addr);
            chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].x_mem_wdata);
            chk($sformatf("v%0d_if_valid", i), 32'(if_valid), 32'(vecs[i].x_if_valid));
            chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].x_if_rdata);
            chk($sformatf("v%0d_dm_valid", i), 32'(dm_valid), 32'(vecs[i].x_dm_valid));
            chk($sformatf("v%0d_dm_rdata", i), dm_rdata, vecs[i].x_dm_rdata);
            chk($sformatf("v%0d_stall_f", i), 32'(stall_f), 32'(vecs[i].x_stall_f));
            chk($sformatf("v%0d_stall_m", i), 32'(stall_m), 32'(vecs[i].x_stall_m));
        end

        // Conflict right after reset: D, then I, then D again
        cyc(); idle_inputs(); rst = 1'b1; smp();
        cyc(); rst = 1'b0; if_req = 1'b1; if_addr = 32'h500; dm_req = 1'b1; dm_addr = 32'h200; smp();
        chk("cf_stall_f", 32'(stall_f), 32'(H));
        chk("cf_stall_m", 32'(stall_m), 32'(H));
        cyc(); mem_ack = 1'b1; mem_rdata = 32'hAAAA_0001; smp();
        chk("cf1_mem_req", 32'(mem_req), 32'(H));
        chk("cf1_mem_addr", mem_addr, 32'h200);
        cyc(); mem_ack = 1'b0; smp();
        chk("cf1_dm_valid", 32'(dm_valid), 32'(H));
        chk("cf1_dm_rdata", dm_rdata, 32'hAAAA_0001);
        chk("cf1_if_valid", 32'(if_valid), 32'(L));
        cyc(); dm_req = 1'b0; smp();
        chk("cf_idle_mem_req", 32'(mem_req), 32'(L));
        cyc(); dm_req = 1'b1; dm_addr = 32'h204; mem_ack = 1'b1; mem_rdata = 32'h1111_1111; smp();
        chk("cf2_mem_req", 32'(mem_req), 32'(H));
        chk("cf2_mem_addr", mem_addr, 32'h500);
        cyc(); mem_ack = 1'b0; smp();
        chk("cf2_if_valid", 32'(if_valid), 32'(H));
        chk("cf2_if_rdata", if_rdata, 32'h1111_1111);
        chk("cf2_dm_valid", 32'(dm_valid), 32'(L));
        cyc(); if_addr = 32'h504; smp();
        chk("cf3_idle_mem_req", 32'(mem_req), 32'(L));
        cyc(); mem_ack = 1'b1; mem_rdata = 32'h2222_2222; smp();
        chk("cf3_mem_req", 32'(mem_req), 32'(H));
        chk("cf3_mem_addr", mem_addr, 32'h204);
        cyc(); mem_ack = 1'b0; smp();
        chk("cf3_dm_valid", 32'(dm_valid), 32'(H));
        chk("cf3_dm_rdata", dm_rdata, 32'h2222_2222);
        cyc(); dm_req = 1'b0; if_req = 1'b0; smp();
        chk("cf_end_if_valid", 32'(if_valid), 32'(L));

        // Kill while the fetch is outstanding
        cyc(); if_req = 1'b1; if_addr = 32'h180; smp();
        chk("kl_stall_f_pre", 32'(stall_f), 32'(H));
        cyc(); if_kill = 1'b1; smp();
        chk("kl_mem_addr", mem_addr, 32'h180);
        chk("kl_stall_f_kill", 32'(stall_f), 32'(L));
        cyc(); if_kill = 1'b0; if_addr = 32'h300; mem_ack = 1'b1; mem_rdata = 32'h7777_7777; smp();
        chk("kl_mem_req_held", 32'(mem_req), 32'(H));
        chk("kl_if_valid_ack", 32'(if_valid), 32'(L));
        cyc(); mem_ack = 1'b0; smp();
        chk("kl_if_valid_after", 32'(if_valid), 32'(L));
        chk("kl_idle_mem_req", 32'(mem_req), 32'(L));
        cyc(); mem_ack = 1'b1; mem_rdata = 32'h8888_8888; smp();
        chk("kl_next_mem_req", 32'(mem_req), 32'(H));
        chk("kl_next_mem_addr", mem_addr, 32'h300);
        cyc(); mem_ack = 1'b0; smp();
        chk("kl_next_if_valid", 32'(if_valid), 32'(H));
        chk("kl_next_if_rdata", if_rdata, 32'h8888_8888);
        cyc(); if_req = 1'b0; smp();
        chk("kl_end_if_valid", 32'(if_valid), 32'(L));

        // Watchdog: load that never gets an ack
        cyc(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3C0; smp();
        chk("to_err_before", 32'(timeout_err), 32'(L));
        for (int i = 0; i < 16; i++) begin
            cyc(); smp();
            chk($sformatf("to_mem_req_%0d", i), 32'(mem_req), 32'(H));
        end
        cyc(); smp();
        chk("to_mem_req_drop", 32'(mem_req), 32'(L));
        chk("to_dm_valid", 32'(dm_valid), 32'(H));
        chk("to_dm_rdata", dm_rdata, 32'h0);
        chk("to_err_set", 32'(timeout_err), 32'(H));
        cyc(); dm_req = 1'b0; smp();
        chk("to_dm_valid_end", 32'(dm_valid), 32'(L));
        repeat (3) cyc();
        smp();
        chk("to_err_sticky", 32'(timeout_err), 32'(H));

        // Reset in the middle of a data access; the late ack must be ignored
        cyc(); dm_req = 1'b1; dm_addr = 32'h2F0; smp();
        cyc(); smp();
        chk("rm_mem_req", 32'(mem_req), 32'(H));
        cyc(); rst = 1'b1; dm_req = 1'b0; smp();
        cyc(); rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h9999_9999; smp();
        chk("rm_mem_req_rst", 32'(mem_req), 32'(L));
        chk("rm_err_clr", 32'(timeout_err), 32'(L));
        chk("rm_dm_valid0", 32'(dm_valid), 32'(L));
        cyc(); smp();
        chk("rm_dm_valid1", 32'(dm_valid), 32'(L));
        chk("rm_mem_req1", 32'(mem_req), 32'(L));
        chk("rm_dm_rdata", dm_rdata, 32'h0);
        cyc(); mem_ack = 1'b0; smp();
        chk("rm_dm_valid2", 32'(dm_valid), 32'(L));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one unified single-port memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage RISC-V pipeline. It sequences each access through a request/ack handshake with a variable-latency memory, returns read data to the winning stage, and generates the stall signals that freeze the pipeline while an access is outstanding. A wait-cycle watchdog and a fetch-kill input cover hung memory and taken branches.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_WAIT, 15, wait-state cycles without mem_ack before timeout (≥1)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch access requested; held with if_addr stable until if_valid or if_kill
- if_addr  in  ADDR_W  fetch address
- if_kill  in  1  squash the outstanding or pending fetch (branch taken, PCSrcE)
- if_rdata  out  DATA_W  instruction word; valid when if_valid
- if_valid  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data access requested; held stable until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data; valid when dm_valid
- dm_valid  out  1  one-cycle completion pulse for data
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle
- mem_rdata  in  DATA_W  memory read data
- stall_f  out  1  freeze PC and the IF/ID register
- stall_m  out  1  freeze the whole pipeline
- timeout_err  out  1  sticky watchdog flag

## Operation
- FSM states: IDLE, I_WAIT, D_WAIT, I_RESP, D_RESP.
- IDLE: dm_req only → D_WAIT. if_req only and not if_kill → I_WAIT. Both pending → grant the side opposite last_grant. last_grant resets to I, so the first conflict goes to D. On grant, latch addr/we/wdata into the mem_* registers, set mem_req=1, update last_grant.
- *_WAIT: hold mem_req and mem_* stable. On mem_ack, capture mem_rdata and drop mem_req. D_WAIT → D_RESP. I_WAIT → I_RESP, or → IDLE if kill_pend.
- *_RESP: pulse if_valid or dm_valid for exactly one cycle, then go to IDLE unconditionally. A requester's req seen in the following IDLE cycle belongs to the next instruction. No re-issue is possible.
- if_kill while in I_WAIT sets kill_pend. The memory transaction still completes, but if_valid is suppressed. if_kill in I_RESP also suppresses if_valid. if_kill in IDLE blocks an I grant that cycle. kill_pend clears on leaving I_WAIT.
- Stores: dm_valid pulses on completion and dm_rdata holds its previous value.
- Watchdog: wait_cnt clears on grant and increments each *_WAIT cycle without ack. When wait_cnt == MAX_WAIT: drop mem_req, set timeout_err, go to the matching RESP state. The returned data is 32'h0000_0013 (NOP) for fetch and 0 for data. timeout_err clears only on rst.
- stall_m = dm_req & ~dm_valid (combinational).
- stall_f = (if_req & ~if_valid & ~if_kill) | stall_m.
- mem_ack is ignored in IDLE and RESP states.

## Timing
- Reset values: state=IDLE, last_grant=I, mem_req/mem_we=0, mem_addr/mem_wdata=0, if_rdata/dm_rdata=0, if_valid/dm_valid=0, timeout_err=0, kill_pend=0, wait_cnt=0.
- rst mid-transaction → IDLE on the next edge with mem_req=0. The in-flight ack is discarded.
- Request seen in IDLE at cycle t → mem_req=1 at t+1 → mem_ack at t+1+k (k≥0 wait states) → valid at t+2+k. Minimum latency is 3 cycles per access.
- Fetch and data can never be granted in the same cycle. Back-to-back conflicting requests alternate I/D.

## Structure
- Shared package riscv_mem_pkg:
  - state enum
  - grant_t {GNT_I, GNT_D}
  - NOP_INSTR = 32'h0000_0013
  - default ADDR_W/DATA_W constants
- One sub-module, mem_wait_timer (wait_cnt plus timeout compare, parameter MAX_WAIT). Everything else stays in mem_port_arbiter.

## Test plan
- Zero-wait fetch: if_req=1, if_addr=0x100, mem_ack the cycle after mem_req, mem_rdata=0x00500093 → if_valid one cycle at t+2, if_rdata=0x00500093, stall_f high through t+1 and low at t+2.
- Conflict: if_req and dm_req (load, 0x200) both rise at reset exit → D granted first and mem_addr=0x200, then I granted, then the next conflict grants D again.
- Store, 3 wait states: dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF → mem_we=1 and mem_wdata stable for 4 cycles, dm_valid at t+5, dm_rdata unchanged, stall_m low at t+5.
- Kill: if_kill pulsed in I_WAIT → no if_valid, state returns to IDLE after ack, next if_req (0x300) is granted normally.
- Timeout: MAX_WAIT=15, mem_ack never asserted on a load → mem_req drops after 15 wait cycles, dm_valid with dm_rdata=0, timeout_err=1 and stays 1 until rst.
- Reset mid-D_WAIT: rst for one cycle → IDLE, mem_req=0 next edge; a late mem_ack produces no valid pulse.
